button_event_decoder: RTL and testbench

Consumes the clean, debounced push-button level produced by the switch debouncer and turns it into single-cycle event pulses for downstream control logic: press, release, short click, long press and (optionally) double click. Sits directly after the debouncer in the same clock domain, at the far end of the button path. It is a cycle-counting state machine with no combinational path from input to outputs.

---
 rtl/button_event_decoder.sv | 153 +++++++++++++++
 tb/tb_button_event_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a debounced push-button level into one-cycle press/release/click/long-press events.
// Optional double-click detection is compiled in when DOUBLE_CLICK_EN is defined.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES = 100_000_000,
    parameter int unsigned DC_WINDOW   = 30_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic click,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam int unsigned CNT_MAX = (LONG_CYCLES > DC_WINDOW) ? LONG_CYCLES : DC_WINDOW;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DC_WINDOW - 1);
`endif

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2
`ifdef DOUBLE_CLICK_EN
        ,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
`endif
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pb_q;
    logic             rise;
    logic             fall;
    logic             timed;
    logic             click_next;
    logic             long_next;
`ifdef DOUBLE_CLICK_EN
    logic             dbl_next;
`endif

    assign rise = pb_in & ~pb_q;
    assign fall = ~pb_in & pb_q;

    always_comb begin
        state_next = state;
        click_next = 1'b0;
        long_next  = 1'b0;
`ifdef DOUBLE_CLICK_EN
        dbl_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) state_next = PRESSED;
            end
            PRESSED: begin
                if (fall) begin
`ifdef DOUBLE_CLICK_EN
                    state_next = WAIT_SECOND;
`else
                    state_next = IDLE;
                    click_next = 1'b1;
`endif
                end else if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) state_next = IDLE;
            end
`ifdef DOUBLE_CLICK_EN
            WAIT_SECOND: begin
                // A second press landing on the expiry cycle still counts as a double click
                if (rise) begin
                    state_next = SECOND_PRESSED;
                end else if (cnt == DC_LAST) begin
                    click_next = 1'b1;
                    state_next = IDLE;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    dbl_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = LONG_HELD;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        timed = (state == PRESSED);
`ifdef DOUBLE_CLICK_EN
        timed = timed | (state == WAIT_SECOND) | (state == SECOND_PRESSED);
`endif
        // Restart on every state change; saturate rather than wrap while timing
        if (state_next != state) begin
            cnt_next = '0;
        end else if (timed && (cnt != '1)) begin
            cnt_next = cnt + 1'b1;
        end else begin
            cnt_next = cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            pb_q          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            click         <= 1'b0;
            long_press    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            pb_q          <= pb_in;
            press_pulse   <= rise;
            release_pulse <= fall;
            click         <= click_next;
            long_press    <= long_next;
            busy          <= (state_next != IDLE);
        end
    end

`ifdef DOUBLE_CLICK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            double_click <= 1'b0;
        end else begin
            double_click <= dbl_next;
        end
    end
`else
    assign double_click = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG_CYCLES=50, DC_WINDOW=30); expectations follow DOUBLE_CLICK_EN.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_in = 1'b0;
    logic press_pulse, release_pulse, click, long_press, double_click, busy;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_press = 0, n_release = 0, n_click = 0, n_long = 0, n_dbl = 0;
    int t_press = 0, t_release = 0, t_click = 0, t_long = 0, t_dbl = 0;

`ifdef DOUBLE_CLICK_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_CYCLES(50),
        .DC_WINDOW  (30)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_in        (pb_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .click        (click),
        .long_press   (long_press),
        .double_click (double_click),
        .busy         (busy)
    );

    // event recorder: counts and cycle stamps of each pulse
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (press_pulse === 1'b1)   begin n_press++;   t_press   = cyc; end
        if (release_pulse === 1'b1) begin n_release++; t_release = cyc; end
        if (click === 1'b1)         begin n_click++;   t_click   = cyc; end
        if (long_press === 1'b1)    begin n_long++;    t_long    = cyc; end
        if (double_click === 1'b1)  begin n_dbl++;     t_dbl     = cyc; end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        pb_in = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (press_pulse !== 1'b0)   begin bad++; $display("FAIL reset_press got=%b exp=0", press_pulse); end
        total++; if (release_pulse !== 1'b0) begin bad++; $display("FAIL reset_release got=%b exp=0", release_pulse); end
        total++; if (click !== 1'b0)         begin bad++; $display("FAIL reset_click got=%b exp=0", click); end
        total++; if (long_press !== 1'b0)    begin bad++; $display("FAIL reset_long got=%b exp=0", long_press); end
        total++; if (double_click !== 1'b0)  begin bad++; $display("FAIL reset_dbl got=%b exp=0", double_click); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_click();
        int bp, br, bc, bl, bd, exp_dly;
        bp = n_press; br = n_release; bc = n_click; bl = n_long; bd = n_dbl;
        exp_dly = DC ? 30 : 0;
        pb_in = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL click_busy got=%b exp=1", busy); end
        repeat (15) @(negedge clk);
        pb_in = 1'b0;
        repeat (45) @(negedge clk);
        total++; if (n_press - bp !== 1)   begin bad++; $display("FAIL click_npress got=%0d exp=1", n_press - bp); end
        total++; if (n_release - br !== 1) begin bad++; $display("FAIL click_nrelease got=%0d exp=1", n_release - br); end
        total++; if (n_click - bc !== 1)   begin bad++; $display("FAIL click_nclick got=%0d exp=1", n_click - bc); end
        total++; if (n_long - bl !== 0)    begin bad++; $display("FAIL click_nlong got=%0d exp=0", n_long - bl); end
        total++; if (n_dbl - bd !== 0)     begin bad++; $display("FAIL click_ndbl got=%0d exp=0", n_dbl - bd); end
        total++; if (t_click - t_release !== exp_dly)
            begin bad++; $display("FAIL click_delay got=%0d exp=%0d", t_click - t_release, exp_dly); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL click_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_long();
        int bp, br, bc, bl, bd;
        bp = n_press; br = n_release; bc = n_click; bl = n_long; bd = n_dbl;
        pb_in = 1'b1;
        repeat (80) @(negedge clk);
        pb_in = 1'b0;
        repeat (45) @(negedge clk);
        total++; if (n_long - bl !== 1)    begin bad++; $display("FAIL long_nlong got=%0d exp=1", n_long - bl); end
        total++; if (t_long - t_press !== 50)
            begin bad++; $display("FAIL long_delay got=%0d exp=50", t_long - t_press); end
        total++; if (n_release - br !== 1) begin bad++; $display("FAIL long_nrelease got=%0d exp=1", n_release - br); end
        total++; if (n_click - bc !== 0)   begin bad++; $display("FAIL long_nclick got=%0d exp=0", n_click - bc); end
        total++; if (n_dbl - bd !== 0)     begin bad++; $display("FAIL long_ndbl got=%0d exp=0", n_dbl - bd); end
        total++; if (n_press - bp !== 1)   begin bad++; $display("FAIL long_npress got=%0d exp=1", n_press - bp); end
    endtask

    task automatic test_double(input int gap);
        int br, bc, bl, bd, exp_click, exp_dbl;
        br = n_release; bc = n_click; bl = n_long; bd = n_dbl;
        exp_click = DC ? 0 : 2;
        exp_dbl   = DC ? 1 : 0;
        pb_in = 1'b1;
        repeat (10) @(negedge clk);
        pb_in = 1'b0;
        repeat (gap) @(negedge clk);
        pb_in = 1'b1;
        repeat (10) @(negedge clk);
        pb_in = 1'b0;
        repeat (45) @(negedge clk);
        total++; if (n_dbl - bd !== exp_dbl)
            begin bad++; $display("FAIL dbl%0d_ndbl got=%0d exp=%0d", gap, n_dbl - bd, exp_dbl); end
        total++; if (n_click - bc !== exp_click)
            begin bad++; $display("FAIL dbl%0d_nclick got=%0d exp=%0d", gap, n_click - bc, exp_click); end
        total++; if (n_long - bl !== 0)
            begin bad++; $display("FAIL dbl%0d_nlong got=%0d exp=0", gap, n_long - bl); end
        total++; if (n_release - br !== 2)
            begin bad++; $display("FAIL dbl%0d_nrelease got=%0d exp=2", gap, n_release - br); end
        if (DC) begin
            total++; if (t_dbl !== t_release)
                begin bad++; $display("FAIL dbl%0d_align got=%0d exp=%0d", gap, t_dbl, t_release); end
        end
    endtask

    task automatic test_reset_mid();
        int bc, bd, exp_click;
        logic exp_busy;
        bc = n_click; bd = n_dbl;
        exp_click = DC ? 0 : 1;
        exp_busy  = DC;
        pb_in = 1'b1;
        repeat (10) @(negedge clk);
        pb_in = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== exp_busy) begin bad++; $display("FAIL rmid_busy_before got=%b exp=%b", busy, exp_busy); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        total++; if (n_click - bc !== exp_click)
            begin bad++; $display("FAIL rmid_nclick got=%0d exp=%0d", n_click - bc, exp_click); end
        total++; if (n_dbl - bd !== 0) begin bad++; $display("FAIL rmid_ndbl got=%0d exp=0", n_dbl - bd); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rmid_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_held_reset();
        int bp, bc;
        rst_n = 1'b0;
        pb_in = 1'b1;
        repeat (3) @(negedge clk);
        bp = n_press; bc = n_click;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (press_pulse !== 1'b1) begin bad++; $display("FAIL held_press got=%b exp=1", press_pulse); end
        repeat (5) @(negedge clk);
        pb_in = 1'b0;
        repeat (45) @(negedge clk);
        total++; if (n_press - bp !== 1) begin bad++; $display("FAIL held_npress got=%0d exp=1", n_press - bp); end
        total++; if (n_click - bc !== 1) begin bad++; $display("FAIL held_nclick got=%0d exp=1", n_click - bc); end
    endtask

    initial begin
        test_reset();
        test_click();
        test_long();
        test_double(15);
        test_double(30);
        test_reset_mid();
        test_held_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
